// File: rtl/wb_sram_ctrl.sv
// Wishbone slave to asynchronous SRAM bridge with a programmable number of access cycles per beat.
// Define SRAM_BURST_EN to let incrementing bursts (cti=010) move from ACK straight into the next ACCESS.
module wb_sram_ctrl #(
   parameter int                     ADDR_BITS   = 22,
   parameter int                     DATA_BITS   = 48,
   parameter logic [31-ADDR_BITS:0]  HIGH_ADDR   = '0,
   parameter int                     WAIT_CYCLES = 2
) (
   input  logic                      wbs_clk_i,
   input  logic                      rst_n,
   input  logic                      wbs_cyc_i,
   input  logic                      wbs_stb_i,
   input  logic                      wbs_we_i,
   input  logic [31:2]               wbs_addr_i,
   input  logic [3:0]                wbs_sel_i,
   input  logic [31:0]               wbs_data_i,
   input  logic [2:0]                wbs_cti_i,
   input  logic [1:0]                wbs_bte_i,
   output logic [31:0]               wbs_data_o,
   output logic                      wbs_ack_o,
   output logic                      sram_ce_n,
   output logic                      sram_oe_n,
   output logic                      sram_we_n,
   output logic [DATA_BITS/8-1:0]    sram_be_n,
   output logic [ADDR_BITS-1:2]      sram_addr,
   input  logic [DATA_BITS-1:0]      sram_din,
   output logic [DATA_BITS-1:0]      sram_dout
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_ACK    = 2'd2;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:2] addr_q, addr_d;
   logic                 we_q, we_d;
   logic [31:0]          data_q, data_d;
   logic                 ack_q, ack_d;
   logic                 ce_n_q, ce_n_d;
   logic                 oe_n_q, oe_n_d;
   logic                 we_n_q, we_n_d;
   logic                 run_q, run_d;
   logic                 cs;
   logic                 unused_sig;

   assign cs = wbs_cyc_i & wbs_stb_i & (wbs_addr_i[31:ADDR_BITS] == HIGH_ADDR);

   assign sram_dout  = DATA_BITS'(wbs_data_i);
   assign unused_sig = ^{sram_din, wbs_cti_i, wbs_bte_i};

`ifdef SRAM_BURST_EN
   logic [ADDR_BITS-1:2] wrap_mask;
   logic [ADDR_BITS-1:2] addr_inc;
   logic [ADDR_BITS-1:2] addr_nxt;

   // Wrapping bursts only carry into the low 2/3/4 word-address bits.
   always_comb begin
      wrap_mask = '1;
      case (wbs_bte_i)
         2'b01:   wrap_mask = (ADDR_BITS-2)'(4'h3);
         2'b10:   wrap_mask = (ADDR_BITS-2)'(4'h7);
         2'b11:   wrap_mask = (ADDR_BITS-2)'(4'hF);
         default: wrap_mask = '1;
      endcase
      addr_inc = addr_q + 1'b1;
      addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      data_d  = data_q;
      ack_d   = 1'b0;
      run_d   = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (cs && run_q) begin
               addr_d  = wbs_addr_i[ADDR_BITS-1:2];
               we_d    = wbs_we_i;
               cnt_d   = CNT_LOAD;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!cs) begin
               state_d = S_IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!we_q) begin
                  data_d = sram_din[31:0];
               end
               ack_d   = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
`ifdef SRAM_BURST_EN
            if (cs && (wbs_cti_i == 3'b010) && (wbs_we_i == we_q)) begin
               addr_d  = addr_nxt;
               cnt_d   = CNT_LOAD;
               state_d = S_ACCESS;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      // Strobes are registered, so they follow the state being entered; we_n rises on the last access cycle for hold.
      ce_n_d = (state_d != S_ACCESS);
      oe_n_d = ce_n_d | we_d;
      we_n_d = ce_n_d | ~we_d | (cnt_d == 4'd0);
   end

   always_ff @(posedge wbs_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         data_q  <= 32'd0;
         ack_q   <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         run_q   <= run_d;
      end
   end

   always_comb begin
      sram_be_n      = '1;
      sram_be_n[3:0] = we_q ? ~wbs_sel_i : 4'b0000;
   end

   assign wbs_data_o = data_q;
   assign wbs_ack_o  = ack_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_addr  = addr_q;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Randomized and directed bench for wb_sram_ctrl, with a behavioural SRAM and a word-level reference memory.
// Burst expectations adapt to whether SRAM_BURST_EN is defined.
module tb_wb_sram_ctrl;

   localparam int WAIT = 2;
`ifdef SRAM_BURST_EN
   localparam int SPACING = WAIT + 1;
`else
   localparam int SPACING = WAIT + 2;
`endif

   logic        clk = 1'b0;
   logic        rstN;
   logic        wbCyc, wbStb, wbWe;
   logic [31:2] wbAddr;
   logic [3:0]  wbSel;
   logic [31:0] wbDataI;
   logic [2:0]  wbCti;
   logic [1:0]  wbBte;
   logic [31:0] wbDataO;
   logic        wbAck;
   logic        sramCeN, sramOeN, sramWeN;
   logic [5:0]  sramBeN;
   logic [21:2] sramAddr;
   logic [47:0] sramDin, sramDout;

   logic [47:0] simMem [256];
   logic [47:0] refMem [256];
   logic [31:0] expData;
   int          total = 0;
   int          bad = 0;

   wb_sram_ctrl #(.ADDR_BITS(22), .DATA_BITS(48), .HIGH_ADDR(10'h000), .WAIT_CYCLES(WAIT)) dut (
      .wbs_clk_i(clk), .rst_n(rstN),
      .wbs_cyc_i(wbCyc), .wbs_stb_i(wbStb), .wbs_we_i(wbWe),
      .wbs_addr_i(wbAddr), .wbs_sel_i(wbSel), .wbs_data_i(wbDataI),
      .wbs_cti_i(wbCti), .wbs_bte_i(wbBte),
      .wbs_data_o(wbDataO), .wbs_ack_o(wbAck),
      .sram_ce_n(sramCeN), .sram_oe_n(sramOeN), .sram_we_n(sramWeN),
      .sram_be_n(sramBeN), .sram_addr(sramAddr),
      .sram_din(sramDin), .sram_dout(sramDout)
   );

   always #5 clk = ~clk;

   // Behavioural asynchronous SRAM: reads are combinational, writes commit on the rising edge of we_n.
   assign sramDin = simMem[sramAddr[9:2]];

   always @(posedge sramWeN) begin
      if (sramCeN === 1'b0) begin
         for (int b = 0; b < 6; b++) begin
            if (sramBeN[b] === 1'b0) simMem[sramAddr[9:2]][8*b +: 8] = sramDout[8*b +: 8];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for an ack, counting edges and the cycles each SRAM strobe was seen low before it.
   task automatic waitAck(output logic gotAck, output int edges, output int ceLow, output int oeLow,
                          output int weLow, output logic [5:0] beSeen, output logic [19:0] addrSeen);
      gotAck = 1'b0; edges = 0; ceLow = 0; oeLow = 0; weLow = 0; beSeen = '0; addrSeen = '0;
      while (edges < 40 && !gotAck) begin
         @(posedge clk); #1;
         edges++;
         if (edges == 1) beSeen = sramBeN;
         if (wbAck) begin
            gotAck = 1'b1;
            addrSeen = sramAddr;
         end else begin
            if (!sramCeN) ceLow++;
            if (!sramOeN) oeLow++;
            if (!sramWeN) weLow++;
         end
      end
   endtask

   task automatic applyStimulus(input logic isWrite, input logic [7:0] word, input logic [3:0] sel,
                                input logic [31:0] data);
      logic gotAck; int edges, ceLow, oeLow, weLow; logic [5:0] beSeen; logic [19:0] addrSeen;
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = isWrite; wbAddr = 30'(word);
      wbSel = sel; wbDataI = data; wbCti = 3'b000; wbBte = 2'b00;
      waitAck(gotAck, edges, ceLow, oeLow, weLow, beSeen, addrSeen);
      checkOutput("ackSeen", 64'(gotAck), 64'd1);
      checkOutput("latency", 64'(edges), 64'(WAIT + 1));
      checkOutput("ceLowCycles", 64'(ceLow), 64'(WAIT));
      checkOutput("sramAddr", 64'(addrSeen), 64'(word));
      if (isWrite) begin
         checkOutput("wrOeLow", 64'(oeLow), 64'd0);
         checkOutput("wrWeLow", 64'(weLow), 64'(WAIT - 1));
         checkOutput("wrBeN", 64'(beSeen), 64'({2'b11, ~sel}));
         for (int b = 0; b < 4; b++) begin
            if (sel[b]) refMem[word][8*b +: 8] = data[8*b +: 8];
         end
      end else begin
         checkOutput("rdOeLow", 64'(oeLow), 64'(WAIT));
         checkOutput("rdWeLow", 64'(weLow), 64'd0);
         checkOutput("rdBeN", 64'(beSeen), 64'(6'b110000));
         expData = refMem[word][31:0];
      end
      checkOutput("dataOut", 64'(wbDataO), 64'(expData));
      @(posedge clk); #1;
      wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0;
      checkOutput("ackOneCycle", 64'(wbAck), 64'd0);
      if (isWrite) checkOutput("memWord", 64'(simMem[word]), 64'(refMem[word]));
   endtask

   initial begin
      logic [47:0] v;
      logic [7:0]  w;
      logic [7:0]  burstWords [4];
      logic gotAck; int edges, ceLow, oeLow, weLow; logic [5:0] beSeen; logic [19:0] addrSeen;
      int acks, ceCount;

      for (int i = 0; i < 256; i++) begin
         v = {16'($urandom), 32'($urandom)};
         simMem[i] = v;
         refMem[i] = v;
      end
      simMem[16] = 48'h0000_DEAD_BEEF;
      refMem[16] = 48'h0000_DEAD_BEEF;
      expData = 32'd0;

      rstN = 1'b0; wbCyc = 0; wbStb = 0; wbWe = 0; wbAddr = '0;
      wbSel = '0; wbDataI = '0; wbCti = '0; wbBte = '0;
      #12;
      checkOutput("rstCeN", 64'(sramCeN), 64'd1);
      checkOutput("rstOeN", 64'(sramOeN), 64'd1);
      checkOutput("rstWeN", 64'(sramWeN), 64'd1);
      checkOutput("rstAck", 64'(wbAck), 64'd0);
      checkOutput("rstData", 64'(wbDataO), 64'd0);
      checkOutput("rstAddr", 64'(sramAddr), 64'd0);
      @(negedge clk); rstN = 1'b1;
      @(posedge clk); @(posedge clk); #1;

      // Directed read of byte 0x40 and a half-word write.
      applyStimulus(1'b0, 8'h10, 4'hF, 32'd0);
      checkOutput("deadbeef", 64'(wbDataO), 64'h0000_0000_DEAD_BEEF);
      applyStimulus(1'b1, 8'h21, 4'b0011, 32'h1234_5678);
      checkOutput("wrKeepsData", 64'(wbDataO), 64'h0000_0000_DEAD_BEEF);

      for (int i = 0; i < 12; i++) begin
         w = 8'($urandom_range(0, 255));
         applyStimulus(1'b1, w, 4'($urandom), $urandom);
         applyStimulus(1'b0, w, 4'hF, 32'd0);
         applyStimulus(1'b0, 8'($urandom_range(0, 255)), 4'hF, 32'd0);
      end

      // Unselected address held for ten cycles.
      wbCyc = 1'b1; wbStb = 1'b1; wbAddr = 30'h2000_0000; acks = 0; ceCount = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (wbAck) acks++;
         if (!sramCeN) ceCount++;
      end
      wbCyc = 1'b0; wbStb = 1'b0;
      checkOutput("unselAck", 64'(acks), 64'd0);
      checkOutput("unselCe", 64'(ceCount), 64'd0);

      // Cycle dropped mid-access.
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0; wbAddr = 30'h33;
      @(posedge clk); #1;
      checkOutput("abortStarted", 64'(sramCeN), 64'd0);
      wbCyc = 1'b0; wbStb = 1'b0; acks = 0; ceCount = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (wbAck) acks++;
         if (!sramCeN) ceCount++;
      end
      checkOutput("abortAck", 64'(acks), 64'd0);
      checkOutput("abortCe", 64'(ceCount), 64'd0);
      checkOutput("abortData", 64'(wbDataO), 64'(expData));

      // Reset pulsed during an access.
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0; wbAddr = 30'h44;
      @(posedge clk); #1;
      checkOutput("rstMidStarted", 64'(sramOeN), 64'd0);
      #2 rstN = 1'b0;
      #1;
      checkOutput("rstMidCe", 64'(sramCeN), 64'd1);
      checkOutput("rstMidOe", 64'(sramOeN), 64'd1);
      checkOutput("rstMidAck", 64'(wbAck), 64'd0);
      checkOutput("rstMidData", 64'(wbDataO), 64'd0);
      expData = 32'd0;
      wbCyc = 1'b0; wbStb = 1'b0;
      @(negedge clk); rstN = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      applyStimulus(1'b0, 8'h44, 4'hF, 32'd0);

      // Wrap4 read burst starting at word 0x0E.
      burstWords[0] = 8'h0E; burstWords[1] = 8'h0F; burstWords[2] = 8'h0C; burstWords[3] = 8'h0D;
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0; wbBte = 2'b01; wbSel = 4'hF;
      for (int b = 0; b < 4; b++) begin
         int spacing;
         spacing = 0;
         if (b > 0) begin
            @(posedge clk); #1;
            spacing = 1;
         end
         wbAddr = 30'(burstWords[b]);
         wbCti = (b == 3) ? 3'b111 : 3'b010;
         waitAck(gotAck, edges, ceLow, oeLow, weLow, beSeen, addrSeen);
         checkOutput("burstAck", 64'(gotAck), 64'd1);
         if (b == 0) checkOutput("burstFirstLat", 64'(edges), 64'(WAIT + 1));
         else checkOutput("burstSpacing", 64'(spacing + edges), 64'(SPACING));
         checkOutput("burstAddr", 64'(addrSeen), 64'(burstWords[b]));
         expData = refMem[burstWords[b]][31:0];
         checkOutput("burstData", 64'(wbDataO), 64'(expData));
      end
      @(posedge clk); #1;
      wbCyc = 1'b0; wbStb = 1'b0; wbCti = 3'b000; wbBte = 2'b00;
      @(posedge clk); #1;
      checkOutput("burstEndIdle", 64'(sramCeN), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
